// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared types and constants for the sequential divider.
// Holds the FSM state encoding and the default operand width.
package seq_divider_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring-division iteration.
// Shifts the next dividend bit into the partial remainder, trial-subtracts the
// divisor, and returns the quotient bit and the restored/updated remainder.
// The partial remainder is WIDTH+1 bits wide; the trial subtraction carries
// one extra bit so its borrow is never lost.
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   rem,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic             q_bit,
   output logic [WIDTH:0]   next_rem
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;

   // Shift, trial subtract, keep the difference only when it did not borrow
   always_comb begin
      shifted  = {rem, dvd_msb};
      trial    = shifted - {2'b00, divisor};
      q_bit    = (shifted >= {2'b00, divisor});
      next_rem = (WIDTH+1)'(q_bit ? trial : shifted);
   end

endmodule : div_step

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock.
// Handshake: start is sampled only while busy is low (IDLE or DONE); an
// accepted start captures the operands, busy is high for WIDTH cycles, then
// done pulses for one cycle with quotient/remainder/div_by_zero valid. The
// result registers hold their value until the next done pulse.
// A zero divisor skips the iteration phase and completes on the next cycle.
// Optional build macro SEQ_DIVIDER_SIGNED_EN adds a signed_mode input that
// selects truncating two's-complement division (magnitudes are divided and
// signs applied afterwards; latency is unchanged).
// dbg_state exposes the FSM state for observation.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
   input  logic             signed_mode,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output state_e           dbg_state
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e             state;
   logic [WIDTH:0]     rem_q;
   logic [WIDTH-1:0]   dvd_q;
   logic [WIDTH-1:0]   dvs_q;
   logic [CNT_W-1:0]   cnt;

   logic               accept;
   logic               q_bit;
   logic [WIDTH:0]     next_rem;
   logic [WIDTH-1:0]   dvd_mag;
   logic [WIDTH-1:0]   dvs_mag;
   logic [WIDTH-1:0]   q_raw;
   logic [WIDTH-1:0]   r_raw;
   logic [WIDTH-1:0]   q_res;
   logic [WIDTH-1:0]   r_res;

   assign accept    = start & (state != ST_RUN);
   assign dbg_state = state;

   // Final iteration's quotient includes the bit being produced this cycle
   assign q_raw = {dvd_q[WIDTH-2:0], q_bit};
   assign r_raw = next_rem[WIDTH-1:0];

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .dvd_msb  (dvd_q[WIDTH-1]),
      .divisor  (dvs_q),
      .q_bit    (q_bit),
      .next_rem (next_rem)
   );

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic neg_dvd;
   logic neg_dvs;
   logic q_neg_q;
   logic r_neg_q;

   assign neg_dvd = signed_mode & dividend[WIDTH-1];
   assign neg_dvs = signed_mode & divisor[WIDTH-1];
   // The most-negative magnitude is representable as an unsigned WIDTH value,
   // so most-negative / -1 naturally yields the most-negative pattern.
   assign dvd_mag = neg_dvd ? (~dividend + WIDTH'(1)) : dividend;
   assign dvs_mag = neg_dvs ? (~divisor + WIDTH'(1)) : divisor;
   assign q_res   = q_neg_q ? (~q_raw + WIDTH'(1)) : q_raw;
   assign r_res   = r_neg_q ? (~r_raw + WIDTH'(1)) : r_raw;

   // Capture result signs alongside the operands on an accepted start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
      end else if (accept) begin
         q_neg_q <= neg_dvd ^ neg_dvs;
         r_neg_q <= neg_dvd;
      end
   end
`else
   assign dvd_mag = dividend;
   assign dvs_mag = divisor;
   assign q_res   = q_raw;
   assign r_res   = r_raw;
`endif

   // Control FSM, iteration datapath and registered result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         rem_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         cnt         <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               if (accept) begin
                  if (divisor == '0) begin
                     state       <= ST_DONE;
                     done        <= 1'b1;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= ST_RUN;
                     busy  <= 1'b1;
                     rem_q <= '0;
                     dvd_q <= dvd_mag;
                     dvs_q <= dvs_mag;
                     cnt   <= '0;
                  end
               end
            end
            ST_RUN: begin
               rem_q <= next_rem;
               dvd_q <= q_raw;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST_CNT) begin
                  state       <= ST_DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  quotient    <= q_res;
                  remainder   <= r_res;
                  div_by_zero <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider (WIDTH=8).
// Cycle numbering: the accepting edge is edge 0; "cycle c" is the interval
// between edge c-1 and edge c, observed at its falling edge.
module tb_seq_divider;
   import seq_divider_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
   logic       signed_mode;
`endif
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;
   state_e     dbg_state;

   int checks   = 0;
   int failures = 0;

   // Scoreboard: expected {div_by_zero, remainder, quotient} per done pulse
   logic [16:0] exp_q[$];
   int          done_cycs[$];
   int          busy_first;
   int          busy_last;
   int          busy_cnt;

   seq_divider #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
      .signed_mode (signed_mode),
`endif
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .dbg_state   (dbg_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] pack_res(input logic z, input logic [7:0] r, input logic [7:0] q);
      return {z, r, q};
   endfunction

   // Driver + monitor: call at a falling edge. Launches a start with operands
   // a/b, then watches n_cyc cycles. If inj_cyc > 0 a one-cycle start with
   // operands ia/ib is raised during that cycle. Ends at a falling edge.
   task automatic do_div(input logic [7:0] a, input logic [7:0] b, input int n_cyc,
                         input int inj_cyc, input logic [7:0] ia, input logic [7:0] ib);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      done_cycs.delete();
      busy_first = -1;
      busy_last  = -1;
      busy_cnt   = 0;
      for (int c = 1; c <= n_cyc; c++) begin
         @(negedge clk);
         if (busy) begin
            if (busy_first < 0) busy_first = c;
            busy_last = c;
            busy_cnt++;
         end
         if (done) begin
            done_cycs.push_back(c);
            if (exp_q.size() == 0)
               check_eq("unexpected_done", 32'd1, 32'd0);
            else
               check_eq("result", pack_res(div_by_zero, remainder, quotient), exp_q.pop_front());
         end
         if (c == inj_cyc) begin
            dividend = ia;
            divisor  = ib;
            start    = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      signed_mode = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_q", quotient, 0);
      check_eq("rst_r", remainder, 0);
      check_eq("rst_dbz", div_by_zero, 0);
      check_eq("rst_state", dbg_state, ST_IDLE);

      // 200/7 launched on the very first edge after release
      rst_n = 1'b1;
      exp_q.push_back(pack_res(1'b0, 8'd4, 8'd28));
      do_div(8'd200, 8'd7, 12, 0, 8'd0, 8'd0);
      check_eq("200_7_ndone", done_cycs.size(), 1);
      check_eq("200_7_done_cyc", (done_cycs.size() > 0) ? done_cycs[0] : -1, 9);
      check_eq("200_7_busy_first", busy_first, 1);
      check_eq("200_7_busy_last", busy_last, 8);
      check_eq("200_7_busy_cnt", busy_cnt, 8);
      check_eq("200_7_hold_q", quotient, 28);

      // Divide by zero, then a normal division clears the flag
      exp_q.push_back(pack_res(1'b1, 8'd13, 8'd255));
      do_div(8'd13, 8'd0, 4, 0, 8'd0, 8'd0);
      check_eq("13_0_done_cyc", (done_cycs.size() > 0) ? done_cycs[0] : -1, 1);
      check_eq("13_0_busy_cnt", busy_cnt, 0);
      exp_q.push_back(pack_res(1'b0, 8'd0, 8'd3));
      do_div(8'd9, 8'd3, 11, 0, 8'd0, 8'd0);
      check_eq("9_3_done_cyc", (done_cycs.size() > 0) ? done_cycs[0] : -1, 9);

      // Start during RUN is ignored
      exp_q.push_back(pack_res(1'b0, 8'd0, 8'd10));
      do_div(8'd100, 8'd10, 14, 3, 8'd50, 8'd5);
      check_eq("ign_ndone", done_cycs.size(), 1);

      // Start during the DONE cycle launches the next division back-to-back
      exp_q.push_back(pack_res(1'b0, 8'd0, 8'd10));
      exp_q.push_back(pack_res(1'b0, 8'd5, 8'd9));
      do_div(8'd100, 8'd10, 21, 9, 8'd77, 8'd8);
      check_eq("b2b_ndone", done_cycs.size(), 2);
      check_eq("b2b_done2_cyc", (done_cycs.size() > 1) ? done_cycs[1] : -1, 18);

      // Boundary operands
      exp_q.push_back(pack_res(1'b0, 8'd0, 8'd1));
      do_div(8'd255, 8'd255, 10, 0, 8'd0, 8'd0);
      exp_q.push_back(pack_res(1'b0, 8'd0, 8'd0));
      do_div(8'd0, 8'd5, 10, 0, 8'd0, 8'd0);
      exp_q.push_back(pack_res(1'b0, 8'd1, 8'd127));
      do_div(8'd255, 8'd2, 10, 0, 8'd0, 8'd0);

      // Reset in cycle 4 of 255/1 abandons it
      dividend = 8'd255;
      divisor  = 8'd1;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_done", done, 0);
      check_eq("mid_rst_q", quotient, 0);
      check_eq("mid_rst_r", remainder, 0);
      check_eq("mid_rst_dbz", div_by_zero, 0);
      check_eq("mid_rst_state", dbg_state, ST_IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int n_late = 0;
         for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) n_late++;
         end
         check_eq("abandon_no_done", n_late, 0);
      end

      // Dividend smaller than divisor takes the full latency
      exp_q.push_back(pack_res(1'b0, 8'd5, 8'd0));
      do_div(8'd5, 8'd9, 11, 0, 8'd0, 8'd0);
      check_eq("5_9_done_cyc", (done_cycs.size() > 0) ? done_cycs[0] : -1, 9);

`ifdef SEQ_DIVIDER_SIGNED_EN
      signed_mode = 1'b1;
      exp_q.push_back(pack_res(1'b0, 8'hFF, 8'hFD));
      do_div(8'hF9, 8'd2, 11, 0, 8'd0, 8'd0);
      check_eq("s_m7_2_done_cyc", (done_cycs.size() > 0) ? done_cycs[0] : -1, 9);
      exp_q.push_back(pack_res(1'b0, 8'h00, 8'h80));
      do_div(8'h80, 8'hFF, 11, 0, 8'd0, 8'd0);
      exp_q.push_back(pack_res(1'b0, 8'hFE, 8'hFE));
      do_div(8'hF2, 8'd6, 11, 0, 8'd0, 8'd0);
      exp_q.push_back(pack_res(1'b1, 8'hF9, 8'hFF));
      do_div(8'hF9, 8'd0, 4, 0, 8'd0, 8'd0);
      signed_mode = 1'b0;
      exp_q.push_back(pack_res(1'b0, 8'd1, 8'd124));
      do_div(8'hF9, 8'd2, 11, 0, 8'd0, 8'd0);
`endif

      check_eq("pending_results", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_seq_divider

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (>=2).
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request; sampled only when busy low.
REQ-005 SHALL have port dividend  input  WIDTH  numerator, captured on accepted start.
REQ-006 SHALL have port divisor  input  WIDTH  denominator, captured on accepted start.
REQ-007 SHALL have port busy  output  1  high while a division is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-009 SHALL have port quotient  output  WIDTH  registered result.
REQ-010 SHALL have port remainder  output  WIDTH  registered result.
REQ-011 SHALL have port div_by_zero  output  1  registered flag, valid with done.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; busy high only in RUN.
REQ-013 SHALL accept start in IDLE or DONE: capture operands, go RUN (back-to-back allowed).
REQ-014 SHALL ignore start in RUN; operands not resampled.
REQ-015 SHALL perform restoring division, one quotient bit per cycle, MSB first, WIDTH cycles in RUN.
REQ-016 SHALL use a WIDTH+1-bit partial remainder; no truncation of intermediate subtraction.
REQ-017 SHALL assert done exactly WIDTH+1 cycles after the accepting edge (start edge = cycle 0).
REQ-018 SHALL update quotient/remainder/div_by_zero only on the edge raising done; hold them otherwise.
REQ-019 SHALL, for divisor 0, skip RUN: done at cycle 1, quotient all-ones, remainder = dividend, div_by_zero 1.
REQ-020 SHALL clear div_by_zero on any non-zero-divisor completion.
REQ-021 SHALL give dividend < divisor -> quotient 0, remainder dividend, full WIDTH latency.

Reset
REQ-022 SHALL on rst_n low, asynchronously: state IDLE, busy 0, done 0, quotient 0, remainder 0, div_by_zero 0, internal registers 0.
REQ-023 SHALL abandon an in-flight division on reset; no done pulse for it after release.
REQ-024 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL define macro SEQ_DIVIDER_SIGNED_EN enabling input signed_mode (1 bit, captured with operands).
REQ-026 SHALL, with macro and signed_mode 1: divide magnitudes, quotient sign = XOR of operand signs, remainder sign = dividend sign (truncating); same latency.
REQ-027 SHALL, with macro, return quotient = most-negative, remainder 0, div_by_zero 0 for most-negative / -1.
REQ-028 SHALL, with macro, for signed divide-by-zero return quotient all-ones, remainder = dividend, div_by_zero 1.
REQ-029 SHALL, without macro, omit signed_mode and sign logic; unsigned only.

Structure
REQ-030 SHALL place state enum (IDLE/RUN/DONE) and default WIDTH constant in package seq_divider_pkg.
REQ-031 SHALL use one combinational sub-module div_step (shift, trial subtract, quotient bit, next remainder), instantiated once.
REQ-032 SHALL use a counter of $clog2(WIDTH+1) bits for iteration count.

Verification (WIDTH=8)
REQ-033 SHALL test 200/7 -> quotient 28, remainder 4, done at cycle 9, busy high cycles 1-8.
REQ-034 SHALL test 13/0 -> quotient 255, remainder 13, div_by_zero 1, done at cycle 1; then 9/3 -> 3, 0, flag 0.
REQ-035 SHALL test start pulsed during RUN of 100/10 -> ignored, single done, quotient 10; start in DONE cycle -> next division at cycle 9 after it.
REQ-036 SHALL test rst_n low at cycle 4 of 255/1 -> outputs 0, no done pulse; new 5/9 after release -> 0, 5.
REQ-037 SHALL, with SEQ_DIVIDER_SIGNED_EN, test -7/2 -> quotient -3, remainder -1; -128/-1 -> -128, 0, flag 0.
